// File: rtl/priority_dec.sv
// priority_dec: registered one-hot decoder for the priority-encoder code/valid
// stream. Codes enter a small circular FIFO under a valid/ready handshake. Each
// decoded vector stays on d_out for HOLD cycles. Vectors from consecutive
// queued codes follow each other with no idle cycle between them.
//
// Optional feature: define PRIO_DEC_STALL_CNT_EN to add the stall_cnt[7:0]
// output. It is a saturating count of cycles with in_valid=1 and in_ready=0.
module priority_dec #(
  parameter int unsigned N      = 4,
  // Derived from N; leave at its default.
  parameter int unsigned CODE_W = $clog2(N),
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned HOLD   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CODE_W-1:0]          in_code,
  output logic                       in_ready,
  output logic [N-1:0]               d_out,
  output logic                       d_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
`ifdef PRIO_DEC_STALL_CNT_EN
  ,
  output logic [7:0]                 stall_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HC_W    = $clog2(HOLD + 1);
  localparam int unsigned STALL_W = 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // Registered state
  logic [0:0]        r_state;
  logic [HC_W-1:0]   r_hcnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [N-1:0]      r_d_out;
  logic              r_d_valid;

  // Next-state / datapath wires
  logic [0:0]        w_state_nxt;
  logic [HC_W-1:0]   w_hcnt_nxt;
  logic [N-1:0]      w_d_out_nxt;
  logic              w_d_valid_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_ne;
  logic              w_fifo_full;
  logic [CODE_W-1:0] w_head;
  logic [N-1:0]      w_dec;

  // Wrap-around increment for the circular FIFO pointers
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake and FIFO status, all derived from registered occupancy
  assign w_fifo_full = (r_cnt == CNT_W'(DEPTH));
  assign w_fifo_ne   = (r_cnt != '0);
  assign in_ready    = rst & ~w_fifo_full;
  assign w_push      = in_valid & in_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // Decode the FIFO head: code k drives bit N-1-k
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_dec[i] = (w_head == CODE_W'(N - 1 - i));
    end
  end

  // Next-state and output logic for the IDLE/HOLD sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = r_hcnt;
    w_d_out_nxt   = r_d_out;
    w_d_valid_nxt = r_d_valid;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_pop         = 1'b1;
          w_d_out_nxt   = w_dec;
          w_d_valid_nxt = 1'b1;
          w_hcnt_nxt    = HC_W'(HOLD - 1);
          w_state_nxt   = S_HOLD;
        end else begin
          w_d_out_nxt   = '0;
          w_d_valid_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (r_hcnt != '0) begin
          w_hcnt_nxt = r_hcnt - HC_W'(1);
        end else if (w_fifo_ne) begin
          // Back-to-back load: d_valid never drops between vectors
          w_pop         = 1'b1;
          w_d_out_nxt   = w_dec;
          w_d_valid_nxt = 1'b1;
          w_hcnt_nxt    = HC_W'(HOLD - 1);
        end else begin
          w_d_out_nxt   = '0;
          w_d_valid_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_d_out_nxt   = '0;
        w_d_valid_nxt = 1'b0;
        w_hcnt_nxt    = '0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // Occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_d_out   <= '0;
      r_d_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_d_out   <= w_d_out_nxt;
      r_d_valid <= w_d_valid_nxt;
    end
  end

  // FIFO pointers and occupancy; reset drops every queued code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // FIFO storage, written at the tail on each accepted transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_code;
    end
  end

`ifdef PRIO_DEC_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall_cnt;

  // Saturating count of cycles where upstream is held off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign d_out    = r_d_out;
  assign d_valid  = r_d_valid;
  assign fifo_cnt = r_cnt;
  assign busy     = (r_state == S_HOLD) | w_fifo_ne;

endmodule

// File: tb/tb_priority_dec.sv
// tb_priority_dec: directed checks for priority_dec on two instances.
// u3 uses HOLD=3 and is driven from a per-cycle vector table. u1 uses HOLD=1
// and is driven by hand-written sequences. Both instances share the reset.
module tb_priority_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       v3, v1;
  logic [1:0] c3, c1;
  logic       rdy3, rdy1;
  logic [3:0] d3, d1;
  logic       dv3, dv1;
  logic       busy3, busy1;
  logic [1:0] cnt3, cnt1;
`ifdef PRIO_DEC_STALL_CNT_EN
  logic [7:0] stall3, stall1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  priority_dec #(.N(4), .DEPTH(2), .HOLD(3)) u3 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v3),
    .in_code  (c3),
    .in_ready (rdy3),
    .d_out    (d3),
    .d_valid  (dv3),
    .busy     (busy3),
    .fifo_cnt (cnt3)
`ifdef PRIO_DEC_STALL_CNT_EN
    ,
    .stall_cnt(stall3)
`endif
  );

  priority_dec #(.N(4), .DEPTH(2), .HOLD(1)) u1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .in_code  (c1),
    .in_ready (rdy1),
    .d_out    (d1),
    .d_valid  (dv1),
    .busy     (busy1),
    .fifo_cnt (cnt1)
`ifdef PRIO_DEC_STALL_CNT_EN
    ,
    .stall_cnt(stall1)
`endif
  );

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic [3:0] d;
    logic       dv;
    logic       rdy;
    logic [1:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    // HOLD=3 stream of codes 0..3 with in_valid held; code 3 stalls two cycles
    //          v     code   d_out    dv    rdy   cnt   busy
    tbl[0]  = '{1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 4'b1000, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 2'd2, 1'b1};
    tbl[4]  = '{1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 2'd2, 1'b1};
    tbl[5]  = '{1'b1, 2'd3, 4'b0100, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};

    // Reset held with in_valid asserted
    rst = 1'b0;
    v3 = 1'b1; c3 = 2'd0;
    v1 = 1'b1; c1 = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy3", 32'(rdy3), 32'd0);
    chk("rst_rdy1", 32'(rdy1), 32'd0);
    chk("rst_d3", 32'(d3), 32'd0);
    chk("rst_dv3", 32'(dv3), 32'd0);
    chk("rst_cnt3", 32'(cnt3), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    v3 = 1'b0; v1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_rdy3", 32'(rdy3), 32'd1);
    chk("rel_rdy1", 32'(rdy1), 32'd1);
    chk("rel_d3", 32'(d3), 32'd0);

    // Table-driven HOLD=3 mapping, back-to-back and stall behaviour
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      v3 = tbl[i].v;
      c3 = tbl[i].code;
      #1;
      chk($sformatf("row%0d_d_out", i), 32'(d3), 32'(tbl[i].d));
      chk($sformatf("row%0d_d_valid", i), 32'(dv3), 32'(tbl[i].dv));
      chk($sformatf("row%0d_in_ready", i), 32'(rdy3), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_fifo_cnt", i), 32'(cnt3), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_busy", i), 32'(busy3), 32'(tbl[i].busy));
    end
    v3 = 1'b0;
`ifdef PRIO_DEC_STALL_CNT_EN
    chk("stall3_after_table", 32'(stall3), 32'd2);
    chk("stall1_idle", 32'(stall1), 32'd0);
`endif

    // HOLD=1 single decode of code 2
    @(negedge clk);
    v1 = 1'b1; c1 = 2'd2;
    #1;
    chk("h1_pre_d", 32'(d1), 32'd0);
    chk("h1_pre_rdy", 32'(rdy1), 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    #1;
    chk("h1_q_cnt", 32'(cnt1), 32'd1);
    chk("h1_q_d", 32'(d1), 32'd0);
    chk("h1_q_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    #1;
    chk("h1_out_d", 32'(d1), 32'b0010);
    chk("h1_out_dv", 32'(dv1), 32'd1);
    chk("h1_out_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    #1;
    chk("h1_end_d", 32'(d1), 32'd0);
    chk("h1_end_dv", 32'(dv1), 32'd0);
    chk("h1_end_busy", 32'(busy1), 32'd0);

    // HOLD=1 back-to-back codes 1 then 3
    @(negedge clk);
    v1 = 1'b1; c1 = 2'd1;
    @(negedge clk);
    c1 = 2'd3;
    #1;
    chk("h1b_cnt0", 32'(cnt1), 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    #1;
    chk("h1b_d1", 32'(d1), 32'b0100);
    chk("h1b_cnt1", 32'(cnt1), 32'd1);
    @(negedge clk);
    #1;
    chk("h1b_d2", 32'(d1), 32'b0001);
    chk("h1b_dv2", 32'(dv1), 32'd1);
    chk("h1b_cnt2", 32'(cnt1), 32'd0);
    @(negedge clk);
    #1;
    chk("h1b_d3", 32'(d1), 32'd0);
    chk("h1b_dv3", 32'(dv1), 32'd0);

    // Reset mid-hold on u3 with two codes queued
    @(negedge clk); v3 = 1'b1; c3 = 2'd0;
    @(negedge clk); c3 = 2'd1;
    @(negedge clk); c3 = 2'd2;
    @(negedge clk); c3 = 2'd3;
    #1;
    chk("mr_pre_cnt", 32'(cnt3), 32'd2);
    chk("mr_pre_d", 32'(d3), 32'b1000);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_async_d", 32'(d3), 32'd0);
    chk("mr_async_dv", 32'(dv3), 32'd0);
    chk("mr_async_cnt", 32'(cnt3), 32'd0);
    chk("mr_async_busy", 32'(busy3), 32'd0);
    chk("mr_async_rdy", 32'(rdy3), 32'd0);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mr_post%0d_d", i), 32'(d3), 32'd0);
      chk($sformatf("mr_post%0d_dv", i), 32'(dv3), 32'd0);
      chk($sformatf("mr_post%0d_cnt", i), 32'(cnt3), 32'd0);
    end
`ifdef PRIO_DEC_STALL_CNT_EN
    chk("mr_stall3", 32'(stall3), 32'd0);

    // Saturation: in_valid held long enough to stall well over 255 cycles
    @(negedge clk);
    v3 = 1'b1; c3 = 2'd0;
    repeat (600) @(negedge clk);
    #1;
    chk("sat_stall3", 32'(stall3), 32'hFF);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_stall3_hold", 32'(stall3), 32'hFF);
    v3 = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
